// File: rtl/reg_host_bridge_if.sv
// Host-side request/response handshake bundle for reg_host_bridge.
// master = host, slave = bridge.
interface reg_host_bridge_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_addr;
  logic [3:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/reg_host_bridge.sv
// Bridges a valid/ready host request/response channel onto one downstream register.
// Define ADDR_CHECK_EN to reject host addresses other than MAP_ADDR with an error response.
module reg_host_bridge #(
  parameter logic [1:0] MAP_ADDR = 2'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  reg_host_bridge_if.slave         bus,
  output logic                     reg_wr,
  output logic                     reg_addr,
  output logic [3:0]               reg_din,
  input  logic [3:0]               reg_dout
);

`ifdef ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WR, RD_XFER, RD_CAP, RSP} state_t;

  state_t     state;
  logic       rsp_valid_q;
  logic [3:0] rsp_rdata_q;
  logic       rsp_err_q;
  logic       mapped;

  // With the check disabled every address aliases onto the register.
  assign mapped = (bus.req_addr == MAP_ADDR) || !ADDR_CHECK;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q & ADDR_CHECK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 4'h0;
      rsp_err_q   <= 1'b0;
      reg_wr      <= 1'b0;
      reg_addr    <= 1'b1;
      reg_din     <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (!mapped) begin
              state       <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 4'h0;
            end else if (bus.req_write) begin
              state    <= WR;
              reg_wr   <= 1'b1;
              reg_addr <= 1'b0;
              reg_din  <= bus.req_wdata;
            end else begin
              state    <= RD_XFER;
              reg_addr <= 1'b0;
            end
          end
        end
        WR: begin
          state       <= RSP;
          reg_wr      <= 1'b0;
          reg_addr    <= 1'b1;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 4'h0;
        end
        RD_XFER: begin
          state    <= RD_CAP;
          reg_addr <= 1'b1;
        end
        // Register output is valid one cycle after the select cycle.
        RD_CAP: begin
          state       <= RSP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= reg_dout;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          reg_wr   <= 1'b0;
          reg_addr <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_host_bridge.md
REG_HOST_BRIDGE -- requirements
Module: reg_host_bridge

Interface
REQ-001 Parameter MAP_ADDR, default 2'd0: host address mapped to the downstream register.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_ready  output  1  bridge can accept a request.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  2  host address.
REQ-008 req_wdata  input  4  write data.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  host accepts response.
REQ-011 rsp_rdata  output  4  read data; 4'h0 for writes and errors.
REQ-012 rsp_err  output  1  1 = request rejected (unmapped address).
REQ-013 reg_wr  output  1  downstream register write strobe.
REQ-014 reg_addr  output  1  downstream register select; 0 = active, 1 = no-op.
REQ-015 reg_din  output  4  downstream register write data.
REQ-016 reg_dout  input  4  downstream register output data.

Function
REQ-017 The FSM SHALL have states IDLE, WR, RD_XFER, RD_CAP, RSP.
REQ-018 req_ready SHALL be 1 only in IDLE and not in rst; a request is accepted on an edge with req_valid && req_ready, capturing req_write/req_addr/req_wdata.
REQ-019 IDLE SHALL go to WR (mapped write), RD_XFER (mapped read), or RSP with rsp_err=1 (unmapped, see REQ-031).
REQ-020 WR SHALL last one cycle driving reg_wr=1, reg_addr=0, reg_din=captured wdata, then go to RSP with rsp_err=0, rsp_rdata=4'h0.
REQ-021 RD_XFER SHALL last one cycle driving reg_wr=0, reg_addr=0, then go to RD_CAP.
REQ-022 RD_CAP SHALL drive reg_addr=1, capture reg_dout into rsp_rdata at the next edge, then go to RSP.
REQ-023 In all states other than WR and RD_XFER, the bridge SHALL drive reg_wr=0 and reg_addr=1; reg_din SHALL hold its last value.
REQ-024 RSP SHALL assert rsp_valid with rsp_rdata/rsp_err stable until an edge with rsp_ready=1, then return to IDLE; rsp_valid drops the cycle after the handshake.
REQ-025 Latency from acceptance edge to first rsp_valid-high cycle SHALL be: write 2 edges, read 3 edges, error 1 edge.
REQ-026 reg_* outputs SHALL depend only on state and capture flops; there SHALL be no combinational path from req_* or rsp_ready to any output except req_ready.
REQ-027 A new request SHALL not be accepted in the cycle rsp_valid handshakes; the earliest acceptance is the following edge.

Reset
REQ-028 While rst is sampled high, state SHALL become IDLE and outputs SHALL be: req_ready=0, rsp_valid=0, rsp_rdata=4'h0, rsp_err=0, reg_wr=0, reg_addr=1, reg_din=4'h0.
REQ-029 Reset in any state (including mid-read or with a response pending) SHALL discard the transaction without a response; no reg_wr pulse SHALL occur in the cycle after reset.
REQ-030 The first acceptance after reset SHALL occur no earlier than the first edge with rst low.

Configuration
REQ-031 With ADDR_CHECK_EN defined, req_addr != MAP_ADDR SHALL yield an error response (rsp_err=1, rsp_rdata=4'h0) with no reg_wr or reg_addr=0 cycle; without it, all addresses SHALL alias to the register and rsp_err SHALL be tied to 0.

Verification
REQ-032 Reset, then read MAP_ADDR -> rsp_rdata=4'h5, rsp_err=0, rsp_valid on 3rd edge after acceptance.
REQ-033 Write 4'hA, then read -> reg_wr high exactly one cycle with reg_din=4'hA; read returns 4'hA.
REQ-034 Read with rsp_ready held low 3 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; IDLE one edge after rsp_ready=1.
REQ-035 ADDR_CHECK_EN defined, write 4'h3 to addr 2'd3 -> rsp_err=1 after 1 edge, reg_wr never high; a subsequent read returns the previous value.
REQ-036 rst asserted while in RD_XFER -> all outputs at REQ-028 values next edge, no rsp_valid; a read after reset release returns 4'h5.
